system_0_onchip_mem_arbiter: RTL and testbench

- Two-master arbiter that shares the single-port 32-bit on-chip RAM (3840 words, 12-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM style requesters.
- Uses round-robin grant, waitrequest back-pressure, and readdatavalid generation.
- Sits between the requesters (e.g. CPU data port and audio DMA) and the RAM's slave port. It drives the RAM's address, byteenable, chipselect, write, writedata and clken, and returns its readdata.

---
 rtl/system_0_onchip_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_system_0_onchip_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_0_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 1-cycle-latency on-chip RAM.
// Optional grant locking is enabled by defining SYSTEM_0_ONCHIP_ARB_LOCK_EN.
module system_0_onchip_mem_arbiter #(
    parameter int DEPTH = 3840,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata
);

    localparam int BW = DW / 8;

    logic [AW-1:0] w_addr  [2];
    logic [BW-1:0] w_be    [2];
    logic [DW-1:0] w_wdata [2];
    logic [1:0]    w_rd;
    logic [1:0]    w_wr;
    logic [1:0]    w_req;
    logic [1:0]    w_rr_grant;
    logic [1:0]    w_grant;
    logic [1:0]    w_wait;
    logic [1:0]    w_rdv;
    logic          w_gidx;
    logic          w_any;
    logic          w_sel_wr;
    logic          w_sel_rd;
    logic          w_oor;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_rdata;

    logic          r_last_grant;
    logic          r_rd_pend;
    logic          r_rd_owner;
    logic          r_rd_oor;

    assign w_addr[0]  = m0_address;
    assign w_addr[1]  = m1_address;
    assign w_be[0]    = m0_byteenable;
    assign w_be[1]    = m1_byteenable;
    assign w_wdata[0] = m0_writedata;
    assign w_wdata[1] = m1_writedata;
    assign w_rd       = {m1_read, m0_read};
    assign w_wr       = {m1_write, m0_write};

    // Per-master request, stall and read-valid; valid is masked during reset so
    // a read pending across a reset edge never reports.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign w_req[gi]  = w_rd[gi] | w_wr[gi];
            assign w_wait[gi] = reset | (w_req[gi] & ~w_grant[gi]);
            assign w_rdv[gi]  = r_rd_pend & (r_rd_owner == gi[0]) & ~reset;
        end
    endgenerate

    always_comb begin
        w_rr_grant = w_req;
        if (w_req == 2'b11) begin
            w_rr_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
    logic [1:0] w_lock;
    logic       r_lock_act;
    logic       r_lock_own;

    assign w_lock = {m1_lock, m0_lock};

    // A locked owner keeps the bus; if it idles with lock still high nobody is granted.
    always_comb begin
        w_grant = w_rr_grant;
        if (r_lock_act) begin
            if (w_req[r_lock_own]) begin
                w_grant = r_lock_own ? 2'b10 : 2'b01;
            end else if (w_lock[r_lock_own]) begin
                w_grant = 2'b00;
            end
        end
        if (reset) begin
            w_grant = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_act <= 1'b0;
            r_lock_own <= 1'b0;
        end else if (w_any) begin
            r_lock_act <= w_lock[w_gidx];
            r_lock_own <= w_gidx;
        end else if (r_lock_act && !w_lock[r_lock_own]) begin
            r_lock_act <= 1'b0;
        end
    end
`else
    always_comb begin
        w_grant = w_rr_grant;
        if (reset) begin
            w_grant = 2'b00;
        end
    end
`endif

    assign w_gidx     = w_grant[1];
    assign w_any      = |w_grant;
    assign w_sel_addr = w_addr[w_gidx];
    assign w_sel_wr   = w_wr[w_gidx];
    // Simultaneous read+write is treated as a write with no read response.
    assign w_sel_rd   = w_rd[w_gidx] & ~w_sel_wr;
    assign w_oor      = {1'b0, w_sel_addr} >= (AW+1)'(DEPTH);

    assign mem_address    = w_sel_addr;
    assign mem_byteenable = w_sel_rd ? {BW{1'b1}} : w_be[w_gidx];
    assign mem_writedata  = w_wdata[w_gidx];
    assign mem_chipselect = w_any & ~w_oor;
    assign mem_write      = w_any & w_sel_wr;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            if (w_any) begin
                r_last_grant <= w_gidx;
            end
            r_rd_pend <= w_any & w_sel_rd;
            if (w_any && w_sel_rd) begin
                r_rd_owner <= w_gidx;
                r_rd_oor   <= w_oor;
            end
        end
    end

    // Out-of-range reads never strobed the RAM, so its output is stale and must be masked.
    assign w_rdata = r_rd_oor ? '0 : mem_readdata;

    assign m0_waitrequest   = w_wait[0];
    assign m1_waitrequest   = w_wait[1];
    assign m0_readdatavalid = w_rdv[0];
    assign m1_readdatavalid = w_rdv[1];
    assign m0_readdata      = w_rdata;
    assign m1_readdata      = w_rdata;

endmodule

// File: tb/tb_system_0_onchip_mem_arbiter.sv
// Directed bench for system_0_onchip_mem_arbiter with a behavioural 3840-word RAM behind it.
module tb_system_0_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    logic [31:0] ram [0:3839];

    always #5 clk = ~clk;

    system_0_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Behavioural RAM: byte-enabled write, registered read, only when selected.
    always @(posedge clk) begin
        logic [31:0] merged;
        if (mem_clken && mem_chipselect && mem_address < 12'd3840) begin
            if (mem_write) begin
                merged = ram[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) merged[8*b +: 8] = mem_writedata[8*b +: 8];
                ram[mem_address] <= merged;
                wr_count <= wr_count + 1;
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic m0_req(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic m1_req(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    initial begin
        for (int i = 0; i < 3840; i++) ram[i] = 32'hC0DE0000 | i;
        mem_readdata = 32'h0;
        reset = 1'b1;
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        m1_req(0, 0, 12'h0, 4'h0, 32'h0);
`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        next_cyc();
        mid();
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_wr", 32'(mem_write), 32'd0);
        chk("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        chk("clken", 32'(mem_clken), 32'd1);

        // m0 write then read back
        next_cyc();
        reset = 1'b0;
        m0_req(0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        mid();
        chk("t1_wr_wait", 32'(m0_waitrequest), 32'd0);
        chk("t1_wr_cs", 32'(mem_chipselect), 32'd1);
        chk("t1_wr_we", 32'(mem_write), 32'd1);
        chk("t1_wr_addr", 32'(mem_address), 32'h010);
        next_cyc();
        m0_req(1, 0, 12'h010, 4'h0, 32'h0);
        mid();
        chk("t1_rd_wait", 32'(m0_waitrequest), 32'd0);
        chk("t1_rd_be", 32'(mem_byteenable), 32'hF);
        chk("t1_rd_we", 32'(mem_write), 32'd0);
        chk("t1_no_rdv_after_wr", 32'(m0_readdatavalid), 32'd0);
        next_cyc();
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        mid();
        chk("t1_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
        chk("t1_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        next_cyc();
        mid();
        chk("t1_rdv_pulse", 32'(m0_readdatavalid), 32'd0);

        // m1 partial write over preset
        next_cyc();
        m1_req(0, 1, 12'h020, 4'hF, 32'hAAAAAAAA);
        mid();
        chk("t3_wait", 32'(m1_waitrequest), 32'd0);
        next_cyc();
        m1_req(0, 1, 12'h020, 4'b0101, 32'h11223344);
        mid();
        chk("t3_be", 32'(mem_byteenable), 32'h5);
        next_cyc();
        m1_req(1, 0, 12'h020, 4'h0, 32'h0);
        mid();
        chk("t3_rd_addr", 32'(mem_address), 32'h020);
        next_cyc();
        m1_req(0, 0, 12'h0, 4'h0, 32'h0);
        mid();
        chk("t3_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("t3_rdata", m1_readdata, 32'hAA22AA44);
        chk("t3_m0_rdv", 32'(m0_readdatavalid), 32'd0);

        // out-of-range write and read
        next_cyc();
        m0_req(0, 1, 12'hF00, 4'hF, 32'h12345678);
        mid();
        chk("t4_wr_wait", 32'(m0_waitrequest), 32'd0);
        chk("t4_wr_cs", 32'(mem_chipselect), 32'd0);
        next_cyc();
        m0_req(1, 0, 12'hF00, 4'hF, 32'h0);
        mid();
        chk("t4_rd_wait", 32'(m0_waitrequest), 32'd0);
        chk("t4_rd_cs", 32'(mem_chipselect), 32'd0);
        next_cyc();
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        mid();
        chk("t4_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("t4_rdata", m0_readdata, 32'h0);
        chk("t4_ram_writes", 32'(wr_count), 32'd3);

        // read accepted, then reset: pending read discarded
        next_cyc();
        m0_req(1, 0, 12'h010, 4'hF, 32'h0);
        mid();
        chk("t5_acc", 32'(m0_waitrequest), 32'd0);
        next_cyc();
        reset = 1'b1;
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        mid();
        chk("t5_no_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("t5_rst_wait", 32'(m0_waitrequest), 32'd1);

        // continuous reads from both masters after reset: m0 first, then alternate
        next_cyc();
        reset = 1'b0;
        m0_req(1, 0, 12'h001, 4'hF, 32'h0);
        m1_req(1, 0, 12'h002, 4'hF, 32'h0);
        mid();
        chk("t2a_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("t2a_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("t2a_addr", 32'(mem_address), 32'h001);
        chk("t2a_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        next_cyc();
        mid();
        chk("t2b_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("t2b_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("t2b_addr", 32'(mem_address), 32'h002);
        chk("t2b_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("t2b_m0_data", m0_readdata, 32'hC0DE0001);
        next_cyc();
        mid();
        chk("t2c_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("t2c_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("t2c_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("t2c_m1_data", m1_readdata, 32'hC0DE0002);
        next_cyc();
        mid();
        chk("t2d_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("t2d_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("t2d_m0_data", m0_readdata, 32'hC0DE0001);
        next_cyc();
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        m1_req(0, 0, 12'h0, 4'h0, 32'h0);
        mid();
        chk("t2e_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("t2e_m0_rdv", 32'(m0_readdatavalid), 32'd0);

`ifdef SYSTEM_0_ONCHIP_ARB_LOCK_EN
        // m0 solo access so m1 wins the next conflict, then m1 holds the bus via lock
        next_cyc();
        m0_req(1, 0, 12'h001, 4'hF, 32'h0);
        next_cyc();
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            m0_req(1, 0, 12'h001, 4'hF, 32'h0);
            m1_req(0, 1, 12'h030 + 12'(k), 4'hF, 32'h55000000 | k);
            m1_lock = (k < 3);
            mid();
            chk("lk_m1_wait", 32'(m1_waitrequest), 32'd0);
            chk("lk_m0_wait", 32'(m0_waitrequest), 32'd1);
        end
        next_cyc();
        m1_req(0, 0, 12'h0, 4'h0, 32'h0);
        m1_lock = 1'b0;
        mid();
        chk("lk_m0_grant", 32'(m0_waitrequest), 32'd0);
        next_cyc();
        m0_req(0, 0, 12'h0, 4'h0, 32'h0);
`endif

        next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
